// File: rtl/edge_pkg.sv
// Shared edge-mode encodings and helpers for the multi-channel edge detector.
// Mode field per channel: 00 off, 01 rise, 10 fall, 11 both.
package edge_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] EDGE_OFF  = 2'b00;
    localparam logic [MODE_W-1:0] EDGE_RISE = 2'b01;
    localparam logic [MODE_W-1:0] EDGE_FALL = 2'b10;
    localparam logic [MODE_W-1:0] EDGE_BOTH = 2'b11;

    function automatic logic rise_enabled(input logic [MODE_W-1:0] mode);
        return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    endfunction

    function automatic logic fall_enabled(input logic [MODE_W-1:0] mode);
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, optional glitch filter (GLITCH_FILTER_EN), edge detect, sticky pend/ovf.
// Latency input->pulse SYNC_STAGES+1 cycles (+FILT_CNT with filter); no backpressure, pulses are 1 cycle.
// pend_nxt is exported so the top can register irq in the same cycle pend updates.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int FILT_CNT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic [MODE_W-1:0] mode,
    input  logic              clr,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic              pend,
    output logic              ovf,
    output logic              pend_nxt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl;
    logic                   lvl_d;
    logic                   evt;
    logic                   ovf_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CNT - 1);

    logic [FILT_W-1:0] cnt;

    // A level change is accepted only after FILT_CNT consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (s != lvl) begin
            if (cnt == CNT_LAST) begin
                lvl <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    assign lvl = s;
`endif

    // lvl_d tracks lvl regardless of mode so re-enabling never reports stale history.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_d      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            pend       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            lvl_d      <= lvl;
            rise_pulse <= lvl & ~lvl_d & rise_enabled(mode);
            fall_pulse <= ~lvl & lvl_d & fall_enabled(mode);
            pend       <= pend_nxt;
            ovf        <= ovf_nxt;
        end
    end

    // A new event beats a coincident clear on pend; ovf honours the clear.
    always_comb begin
        evt      = rise_pulse | fall_pulse;
        pend_nxt = evt | (pend & ~clr);
        ovf_nxt  = ~clr & (ovf | (evt & pend));
    end

endmodule

// File: rtl/multi_edge_detect.sv
// CH-channel edge detector with masked aggregate irq; glitch filter enabled by GLITCH_FILTER_EN.
// Latency input->pulse SYNC_STAGES+1 (+FILT_CNT filtered), irq one cycle after pulse.
// No backpressure: pulses are fire-and-forget, pend/ovf are sticky until clr.
module multi_edge_detect
    import edge_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int FILT_CNT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     data_in,
    input  logic [2*CH-1:0]   edge_mode,
    input  logic [CH-1:0]     irq_mask,
    input  logic [CH-1:0]     clr,
    output logic [CH-1:0]     rise_pulse,
    output logic [CH-1:0]     fall_pulse,
    output logic [CH-1:0]     pend,
    output logic [CH-1:0]     ovf,
    output logic              irq
);

    logic [CH-1:0] pend_nxt;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .FILT_CNT    (FILT_CNT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .din        (data_in[i]),
            .mode       (edge_mode[MODE_W*i +: MODE_W]),
            .clr        (clr[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .pend       (pend[i]),
            .ovf        (ovf[i]),
            .pend_nxt   (pend_nxt[i])
        );
    end

    // Registered from next-state pend so irq lines up with the pend register.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pend_nxt & irq_mask);
        end
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench: stimulus pushes expected pulses into a queue, a negedge monitor pops and compares.
module tb_multi_edge_detect;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FW = 4;
    localparam int FC = 3;
`ifdef GLITCH_FILTER_EN
    localparam int LAT = SS + FC + 1;
`else
    localparam int LAT = SS + 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   data_in;
    logic [2*CH-1:0] edge_mode;
    logic [CH-1:0]   irq_mask;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   rise_pulse;
    logic [CH-1:0]   fall_pulse;
    logic [CH-1:0]   pend;
    logic [CH-1:0]   ovf;
    logic            irq;

    multi_edge_detect #(
        .CH          (CH),
        .SYNC_STAGES (SS),
        .FILT_W      (FW),
        .FILT_CNT    (FC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .edge_mode  (edge_mode),
        .irq_mask   (irq_mask),
        .clr        (clr),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .pend       (pend),
        .ovf        (ovf),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t mon_p;
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                mon_p = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: cycle %0d saw nothing, required rise=%b fall=%b",
                         mon_p.at, mon_p.rise, mon_p.fall);
            end
            if ((rise_pulse | fall_pulse) != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cycle %0d rise=%b fall=%b, required none",
                             cyc, rise_pulse, fall_pulse);
                end else begin
                    mon_p = exp_q.pop_front();
                    if (mon_p.at != cyc || mon_p.rise != rise_pulse || mon_p.fall != fall_pulse) begin
                        errors++;
                        $display("FAIL pulse: cycle %0d rise=%b fall=%b, required cycle %0d rise=%b fall=%b",
                                 cyc, rise_pulse, fall_pulse, mon_p.at, mon_p.rise, mon_p.fall);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at, input logic [CH-1:0] r, input logic [CH-1:0] f);
        pulse_t p;
        p.at   = at;
        p.rise = r;
        p.fall = f;
        exp_q.push_back(p);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"}, 32'(rise_pulse), 32'h0);
        chk({tag, "_fall"}, 32'(fall_pulse), 32'h0);
        chk({tag, "_pend"}, 32'(pend), 32'h0);
        chk({tag, "_ovf"}, 32'(ovf), 32'h0);
        chk({tag, "_irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        data_in   = '0;
        edge_mode = '0;
        irq_mask  = '0;
        clr       = '0;
        step(3);
        chk_all_zero("reset");
        mon_en = 1'b1;
        rst    = 1'b0;
        step(2);

        // ch0 rise: pulse after LAT, pend/irq one cycle later
        edge_mode = 8'b00_00_00_01;
        irq_mask  = 4'b0001;
        step(1);
        data_in[0] = 1'b1;
        expect_pulse(cyc + LAT, 4'b0001, 4'b0000);
        step(LAT);
        chk("pend_before_set", 32'(pend), 32'h0);
        chk("irq_before_set", 32'(irq), 32'h0);
        step(1);
        chk("pend_ch0_set", 32'(pend), 32'h1);
        chk("irq_ch0_set", 32'(irq), 32'h1);
        clr = 4'b0001;
        step(1);
        clr = '0;
        chk("pend_ch0_clr", 32'(pend), 32'h0);
        chk("irq_ch0_clr", 32'(irq), 32'h0);
        data_in[0] = 1'b0;
        step(LAT + 2);
        chk("fall_gated_by_mode", 32'(pend), 32'h0);

        // ch2 both edges without clr -> pend and ovf
        edge_mode = 8'b00_11_00_01;
        step(1);
        data_in[2] = 1'b1;
        expect_pulse(cyc + LAT, 4'b0100, 4'b0000);
        step(4);
        data_in[2] = 1'b0;
        expect_pulse(cyc + LAT, 4'b0000, 4'b0100);
        step(LAT + 2);
        chk("pend_ch2_double", 32'(pend), 32'h4);
        chk("ovf_ch2_double", 32'(ovf), 32'h4);
        chk("irq_ch2_masked", 32'(irq), 32'h0);
        clr = 4'b0100;
        step(1);
        clr = '0;
        chk("pend_ch2_clr", 32'(pend), 32'h0);
        chk("ovf_ch2_clr", 32'(ovf), 32'h0);

        // ch3: pend already set, second pulse coincides with clr
        edge_mode = 8'b01_11_00_01;
        step(1);
        data_in[3] = 1'b1;
        expect_pulse(cyc + LAT, 4'b1000, 4'b0000);
        step(LAT + 1);
        chk("pend_ch3_first", 32'(pend), 32'h8);
        edge_mode = 8'b11_11_00_01;
        step(1);
        data_in[3] = 1'b0;
        expect_pulse(cyc + LAT, 4'b0000, 4'b1000);
        step(LAT);
        clr = 4'b1000;
        step(1);
        clr = '0;
        chk("pend_set_beats_clr", 32'(pend), 32'h8);
        chk("ovf_clr_wins", 32'(ovf), 32'h0);
        chk("irq_ch3_masked", 32'(irq), 32'h0);
        irq_mask = 4'b1001;
        step(1);
        chk("irq_on_unmask", 32'(irq), 32'h1);
        irq_mask = 4'b0001;
        clr      = 4'b1000;
        step(1);
        clr = '0;
        chk("pend_ch3_clr", 32'(pend), 32'h0);
        chk("irq_after_clr", 32'(irq), 32'h0);

        // reset in the middle of propagation on ch1
        edge_mode = 8'b11_11_01_01;
        step(1);
        data_in[1] = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        chk_all_zero("mid_reset");
        step(1);
        rst = 1'b0;
        expect_pulse(cyc + LAT, 4'b0010, 4'b0000);
        step(LAT + 1);
        chk("pend_after_reset", 32'(pend), 32'h2);
        chk("irq_after_reset", 32'(irq), 32'h0);

        // ch0 goes high while off; enabling later must not pulse
        edge_mode = 8'b11_11_01_00;
        step(1);
        data_in[0] = 1'b1;
        step(LAT + 2);
        edge_mode = 8'b11_11_01_01;
        step(3);
        chk("mode_enable_no_pulse", 32'(pend), 32'h2);

        // short glitch then a longer pulse on ch2
        step(1);
        data_in[2] = 1'b1;
`ifndef GLITCH_FILTER_EN
        expect_pulse(cyc + LAT, 4'b0100, 4'b0000);
        expect_pulse(cyc + 2 + LAT, 4'b0000, 4'b0100);
`endif
        step(2);
        data_in[2] = 1'b0;
        step(LAT + 4);
`ifdef GLITCH_FILTER_EN
        chk("pend_after_glitch", 32'(pend), 32'h2);
`else
        chk("pend_after_glitch", 32'(pend), 32'h6);
`endif
        data_in[2] = 1'b1;
        expect_pulse(cyc + LAT, 4'b0100, 4'b0000);
        step(5);
        data_in[2] = 1'b0;
        expect_pulse(cyc + LAT, 4'b0000, 4'b0100);
        step(LAT + 4);
        chk("pend_after_long", 32'(pend), 32'h6);
        chk("ovf_after_long", 32'(ovf), 32'h4);

        step(3);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
